// File: rtl/snitch_icache_pkg.sv
// Shared types for the instruction-cache line refill unit.
//   refill_req_t : registered miss request (line address, victim set, miss ID)
//   cnt_width()  : beat counter width for a given number of beats per line
package snitch_icache_pkg;

   localparam int unsigned FetchAw  = 48;
   localparam int unsigned SetAlign = 1;
   localparam int unsigned IdWidth  = 4;

   // Field widths track the default refill geometry; instances with other
   // address/set/id widths need matching values here.
   typedef struct packed {
      logic [FetchAw-1:0]  addr;
      logic [SetAlign-1:0] set;
      logic [IdWidth-1:0]  id;
   } refill_req_t;

   function automatic int unsigned cnt_width(input int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/snitch_icache_line_refill_if.sv
// Signal bundle around the line refill unit.
//   in_*    : miss request from the cache lookup (refill unit is the sink)
//   mem_*   : line request to memory and returning data beats
//   write_* : line write into the lookup arrays
//   out_*   : completion returned to the fetch side
// Modport master is the refill unit; slave is its environment.
interface snitch_icache_line_refill_if #(
   parameter int unsigned FETCH_AW    = 48,
   parameter int unsigned LINE_WIDTH  = 128,
   parameter int unsigned MEM_DW      = 64,
   parameter int unsigned COUNT_ALIGN = 7,
   parameter int unsigned SET_ALIGN   = 1,
   parameter int unsigned TAG_WIDTH   = 37,
   parameter int unsigned ID_WIDTH    = 4
) ();

   logic [FETCH_AW-1:0]    in_addr_i;
   logic [SET_ALIGN-1:0]   in_set_i;
   logic [ID_WIDTH-1:0]    in_id_i;
   logic                   in_valid_i;
   logic                   in_ready_o;

   logic [FETCH_AW-1:0]    mem_addr_o;
   logic                   mem_valid_o;
   logic                   mem_ready_i;

   logic [MEM_DW-1:0]      mem_rdata_i;
   logic                   mem_rerror_i;
   logic                   mem_rlast_i;
   logic                   mem_rvalid_i;
   logic                   mem_rready_o;

   logic [COUNT_ALIGN-1:0] write_addr_o;
   logic [SET_ALIGN-1:0]   write_set_o;
   logic [LINE_WIDTH-1:0]  write_data_o;
   logic [TAG_WIDTH-1:0]   write_tag_o;
   logic                   write_error_o;
   logic                   write_valid_o;
   logic                   write_ready_i;

   logic [ID_WIDTH-1:0]    out_id_o;
   logic [LINE_WIDTH-1:0]  out_data_o;
   logic                   out_error_o;
   logic                   out_valid_o;
   logic                   out_ready_i;

   modport master (
      input  in_addr_i, in_set_i, in_id_i, in_valid_i,
      output in_ready_o,
      output mem_addr_o, mem_valid_o,
      input  mem_ready_i,
      input  mem_rdata_i, mem_rerror_i, mem_rlast_i, mem_rvalid_i,
      output mem_rready_o,
      output write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
      input  write_ready_i,
      output out_id_o, out_data_o, out_error_o, out_valid_o,
      input  out_ready_i
   );

   modport slave (
      output in_addr_i, in_set_i, in_id_i, in_valid_i,
      input  in_ready_o,
      input  mem_addr_o, mem_valid_o,
      output mem_ready_i,
      output mem_rdata_i, mem_rerror_i, mem_rlast_i, mem_rvalid_i,
      input  mem_rready_o,
      input  write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
      output write_ready_i,
      input  out_id_o, out_data_o, out_error_o, out_valid_o,
      output out_ready_i
   );

endinterface

// File: rtl/snitch_icache_line_refill.sv
// Instruction-cache line refill: accepts one miss, requests the line from
// memory, assembles the returning beats, writes the line into the lookup
// arrays and then reports completion. One miss in flight at a time.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : miss request, memory request/response, lookup write, completion
module snitch_icache_line_refill
   import snitch_icache_pkg::*;
#(
   parameter int unsigned FETCH_AW    = FetchAw,
   parameter int unsigned LINE_WIDTH  = 128,
   parameter int unsigned MEM_DW      = 64,
   parameter int unsigned LINE_ALIGN  = 4,
   parameter int unsigned COUNT_ALIGN = 7,
   parameter int unsigned SET_ALIGN   = SetAlign,
   parameter int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
   parameter int unsigned ID_WIDTH    = IdWidth
) (
   input logic                         clk_i,
   input logic                         rst_ni,
   snitch_icache_line_refill_if.master bus
);

   localparam int unsigned Beats = LINE_WIDTH / MEM_DW;
   localparam int unsigned CntW  = cnt_width(Beats);
   localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

   typedef enum logic [2:0] {StIdle, StReq, StRecv, StWrite, StRsp} state_e;

   state_e                state_q, state_d;
   refill_req_t           req_q, req_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic                  err_q, err_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   // Holds in_ready_o low until the first clock after reset release.
   logic                  armed_q;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      line_d  = line_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      bus.in_ready_o    = 1'b0;
      bus.mem_valid_o   = 1'b0;
      bus.mem_rready_o  = 1'b0;
      bus.write_valid_o = 1'b0;
      bus.out_valid_o   = 1'b0;

      unique case (state_q)
         StIdle: begin
            bus.in_ready_o = armed_q;
            if (armed_q && bus.in_valid_i) begin
               req_d.addr = bus.in_addr_i;
               req_d.set  = bus.in_set_i;
               req_d.id   = bus.in_id_i;
               line_d     = '0;
               err_d      = 1'b0;
               cnt_d      = '0;
               state_d    = StReq;
            end
         end
         StReq: begin
            bus.mem_valid_o = 1'b1;
            if (bus.mem_ready_i) state_d = StRecv;
         end
         StRecv: begin
            bus.mem_rready_o = 1'b1;
            if (bus.mem_rvalid_i) begin
               for (int unsigned b = 0; b < Beats; b++) begin
                  if (cnt_q == b[CntW-1:0]) line_d[b*MEM_DW +: MEM_DW] = bus.mem_rdata_i;
               end
               err_d = err_q | bus.mem_rerror_i;
               cnt_d = cnt_q + 1'b1;
               if (bus.mem_rlast_i || (cnt_q == LastBeat)) begin
                  state_d = StWrite;
                  // Memory ended the burst short: the line is incomplete.
                  if (cnt_q != LastBeat) err_d = 1'b1;
               end
            end
         end
         StWrite: begin
            bus.write_valid_o = 1'b1;
            if (bus.write_ready_i) state_d = StRsp;
         end
         StRsp: begin
            bus.out_valid_o = 1'b1;
            if (bus.out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Payload outputs come straight from registers, so they cannot change
   // while the matching valid is waiting for its ready.
   assign bus.mem_addr_o    = {req_q.addr[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
   assign bus.write_addr_o  = req_q.addr[LINE_ALIGN +: COUNT_ALIGN];
   assign bus.write_tag_o   = req_q.addr[LINE_ALIGN+COUNT_ALIGN +: TAG_WIDTH];
   assign bus.write_set_o   = req_q.set;
   assign bus.write_data_o  = line_q;
   assign bus.write_error_o = err_q;
   assign bus.out_id_o      = req_q.id;
   assign bus.out_data_o    = line_q;
   assign bus.out_error_o   = err_q;

   // Byte offset within the line is captured but never needed.
   logic unused_offset;
   assign unused_offset = ^req_q.addr[LINE_ALIGN-1:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         req_q   <= '0;
         line_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         line_q  <= line_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         armed_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_snitch_icache_line_refill.sv
`timescale 1ns/1ps
module tb_snitch_icache_line_refill;

   localparam int Tmo = 40;

   typedef struct packed {
      logic [6:0]   waddr;
      logic         set;
      logic [36:0]  tag;
      logic [127:0] data;
      logic         err;
   } wr_t;

   typedef struct packed {
      logic [3:0]   id;
      logic [127:0] data;
      logic         err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [47:0] exp_mem_q[$];
   wr_t         exp_wr_q[$];
   rsp_t        exp_rsp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   snitch_icache_line_refill_if #(
      .FETCH_AW(48), .LINE_WIDTH(128), .MEM_DW(64), .COUNT_ALIGN(7),
      .SET_ALIGN(1), .TAG_WIDTH(37), .ID_WIDTH(4)
   ) bus ();

   snitch_icache_line_refill #(
      .FETCH_AW(48), .LINE_WIDTH(128), .MEM_DW(64), .LINE_ALIGN(4), .COUNT_ALIGN(7),
      .SET_ALIGN(1), .TAG_WIDTH(37), .ID_WIDTH(4)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   function automatic void check(input string name, input logic [255:0] act,
                                 input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Scoreboard monitor: compares every handshake against the queued
   // expectation and checks that a stalled valid keeps its payload.
   initial begin : monitor
      logic [255:0] cur_m, cur_w, cur_o, prv_m, prv_w, prv_o;
      logic hold_m, hold_w, hold_o;
      logic [47:0] em;
      wr_t ew;
      rsp_t eo;
      hold_m = 0; hold_w = 0; hold_o = 0;
      prv_m = '0; prv_w = '0; prv_o = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_m = 0; hold_w = 0; hold_o = 0;
         end else begin
            cur_m = {bus.mem_valid_o, bus.mem_addr_o};
            cur_w = {bus.write_valid_o, bus.write_addr_o, bus.write_set_o, bus.write_tag_o,
                     bus.write_data_o, bus.write_error_o};
            cur_o = {bus.out_valid_o, bus.out_id_o, bus.out_data_o, bus.out_error_o};
            if (hold_m) check("mem_req_held", cur_m, prv_m);
            if (hold_w) check("write_held", cur_w, prv_w);
            if (hold_o) check("out_held", cur_o, prv_o);
            if (bus.mem_valid_o && bus.mem_ready_i) begin
               if (exp_mem_q.size() == 0) check("mem_req_unexpected", 1, 0);
               else begin
                  em = exp_mem_q.pop_front();
                  check("mem_addr", bus.mem_addr_o, em);
               end
            end
            if (bus.write_valid_o && bus.write_ready_i) begin
               if (exp_wr_q.size() == 0) check("write_unexpected", 1, 0);
               else begin
                  ew = exp_wr_q.pop_front();
                  check("write_addr", bus.write_addr_o, ew.waddr);
                  check("write_set", bus.write_set_o, ew.set);
                  check("write_tag", bus.write_tag_o, ew.tag);
                  check("write_data", bus.write_data_o, ew.data);
                  check("write_error", bus.write_error_o, ew.err);
               end
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
               if (exp_rsp_q.size() == 0) check("out_unexpected", 1, 0);
               else begin
                  eo = exp_rsp_q.pop_front();
                  check("out_id", bus.out_id_o, eo.id);
                  check("out_data", bus.out_data_o, eo.data);
                  check("out_error", bus.out_error_o, eo.err);
               end
            end
            hold_m = bus.mem_valid_o && !bus.mem_ready_i;
            hold_w = bus.write_valid_o && !bus.write_ready_i;
            hold_o = bus.out_valid_o && !bus.out_ready_i;
            prv_m = cur_m; prv_w = cur_w; prv_o = cur_o;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_in_ready", bus.in_ready_o, 0);
      check("rst_mem_valid", bus.mem_valid_o, 0);
      check("rst_mem_addr", bus.mem_addr_o, 0);
      check("rst_mem_rready", bus.mem_rready_o, 0);
      check("rst_write_valid", bus.write_valid_o, 0);
      check("rst_write_fields", {bus.write_addr_o, bus.write_set_o, bus.write_tag_o,
                                 bus.write_error_o}, 0);
      check("rst_write_data", bus.write_data_o, 0);
      check("rst_out_valid", bus.out_valid_o, 0);
      check("rst_out_fields", {bus.out_id_o, bus.out_error_o}, 0);
      check("rst_out_data", bus.out_data_o, 0);
   endtask

   task automatic issue(input logic [47:0] a, input logic s, input logic [3:0] id);
      bus.in_addr_i = a; bus.in_set_i = s; bus.in_id_i = id; bus.in_valid_i = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (bus.in_ready_o) break;
         if (n == Tmo) begin check("in_timeout", 0, 1); break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
   endtask

   // sel: 0 = memory request, 1 = lookup write, 2 = completion.
   task automatic phase(input int sel, input int stall);
      logic hs;
      for (int n = 0; ; n++) begin
         case (sel)
            0: bus.mem_ready_i = (n >= stall);
            1: bus.write_ready_i = (n >= stall);
            default: bus.out_ready_i = (n >= stall);
         endcase
         @(negedge clk);
         check("in_ready_busy", bus.in_ready_o, 0);
         if (sel == 0) check("rready_in_req", bus.mem_rready_o, 0);
         case (sel)
            0: hs = bus.mem_valid_o && bus.mem_ready_i;
            1: hs = bus.write_valid_o && bus.write_ready_i;
            default: hs = bus.out_valid_o && bus.out_ready_i;
         endcase
         if (hs) break;
         if (n == Tmo) begin check("phase_timeout", sel, 99); break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic e, input logic l);
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = d; bus.mem_rerror_i = e; bus.mem_rlast_i = l;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (bus.mem_rready_o) break;
         if (n == Tmo) begin check("beat_timeout", 0, 1); break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_rerror_i = 1'b0;
      bus.mem_rlast_i = 1'b0;
   endtask

   task automatic run_miss(input logic [47:0] a, input logic s, input logic [3:0] id,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input logic e0, input logic e1, input logic l0,
                           input int ms, input int ws, input int os, input bit early,
                           input logic [47:0] x_mem, input logic [6:0] x_waddr,
                           input logic [36:0] x_tag, input logic [127:0] x_data,
                           input logic x_err, input int x_lat);
      wr_t  w;
      rsp_t r;
      int   t0;
      w.waddr = x_waddr; w.set = s; w.tag = x_tag; w.data = x_data; w.err = x_err;
      r.id = id; r.data = x_data; r.err = x_err;
      exp_mem_q.push_back(x_mem);
      exp_wr_q.push_back(w);
      exp_rsp_q.push_back(r);
      issue(a, s, id);
      t0 = cyc;
      // A beat offered before the line is requested must be left waiting.
      if (early) begin
         bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = d0; bus.mem_rerror_i = e0;
         bus.mem_rlast_i = l0;
      end
      phase(0, ms);
      beat(d0, e0, l0);
      if (!l0) beat(d1, e1, 1'b1);
      phase(1, ws);
      phase(2, os);
      check("latency", cyc - t0, x_lat);
   endtask

   initial begin : stimulus
      bus.in_addr_i = '0; bus.in_set_i = '0; bus.in_id_i = '0; bus.in_valid_i = 1'b0;
      bus.mem_ready_i = 1'b1; bus.write_ready_i = 1'b1; bus.out_ready_i = 1'b1;
      bus.mem_rdata_i = '0; bus.mem_rerror_i = 1'b0; bus.mem_rlast_i = 1'b0;
      bus.mem_rvalid_i = 1'b0;

      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Nominal two-beat refill.
      run_miss(48'h0000_1234_5670, 1'b1, 4'h3, 64'hAAAA_AAAA_AAAA_AAAA,
               64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0,
               48'h0000_1234_5670, 7'h67, 37'h2_468A,
               {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0, 5);

      // Error on beat 0 only; data still delivered.
      run_miss(48'hABCD_EF01_234F, 1'b0, 4'hA, 64'h1111_1111_1111_1111,
               64'h2222_2222_2222_2222, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0,
               48'hABCD_EF01_2340, 7'h34, 37'h15_79BD_E024,
               {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b1, 5);

      // Burst ends after one beat: upper half stays zero, line flagged.
      run_miss(48'h0000_0000_0800, 1'b1, 4'h7, 64'h0123_4567_89AB_CDEF, 64'h0,
               1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0,
               48'h0000_0000_0800, 7'h00, 37'h1,
               {64'h0, 64'h0123_4567_89AB_CDEF}, 1'b1, 4);

      // Backpressure on every channel, with beat 0 offered during the stall.
      run_miss(48'hFFFF_FFFF_FFFF, 1'b1, 4'hF, 64'hDEAD_BEEF_0000_0001,
               64'hCAFE_F00D_0000_0002, 1'b0, 1'b0, 1'b0, 3, 2, 4, 1'b1,
               48'hFFFF_FFFF_FFF0, 7'h7F, 37'h1F_FFFF_FFFF,
               {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001}, 1'b0, 14);

      // Reset after the first beat abandons the miss entirely.
      exp_mem_q.push_back(48'h0000_0000_1230);
      issue(48'h0000_0000_1230, 1'b0, 4'h9);
      phase(0, 0);
      beat(64'h5555_5555_5555_5555, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs();
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_write_valid", bus.write_valid_o, 0);
      @(negedge clk);
      check("in_ready_after_release", bus.in_ready_o, 1);
      @(posedge clk); #1;

      run_miss(48'h0000_0000_1240, 1'b1, 4'h5, 64'h6666_6666_6666_6666, 64'h0,
               1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0,
               48'h0000_0000_1240, 7'h24, 37'h2,
               {64'h0, 64'h6666_6666_6666_6666}, 1'b1, 4);

      repeat (4) @(posedge clk);
      #1;
      check("mem_queue_drained", exp_mem_q.size(), 0);
      check("write_queue_drained", exp_wr_q.size(), 0);
      check("out_queue_drained", exp_rsp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snitch_icache_line_refill.md
SNITCH_ICACHE_LINE_REFILL -- requirements
Module: snitch_icache_line_refill

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FETCH_AW, 48, fetch address width.
- LINE_WIDTH, 128, cache line width in bits.
- MEM_DW, 64, memory beat width; LINE_WIDTH SHALL be an integer multiple of MEM_DW.
- LINE_ALIGN, 4, log2 of line bytes.
- COUNT_ALIGN, 7, log2 of lines per set.
- SET_ALIGN, 1, set index width.
- TAG_WIDTH, 37, equal to FETCH_AW-LINE_ALIGN-COUNT_ALIGN.
- ID_WIDTH, 4, miss ID width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
REQ-003 Miss request port:
- in_addr_i, in, FETCH_AW, miss address.
- in_set_i, in, SET_ALIGN, victim set.
- in_id_i, in, ID_WIDTH, miss ID.
- in_valid_i, in, 1, request valid.
- in_ready_o, out, 1, request ready.
REQ-004 Memory request port:
- mem_addr_o, out, FETCH_AW, line-aligned address.
- mem_valid_o, out, 1, request valid.
- mem_ready_i, in, 1, request ready.
REQ-005 Memory response port:
- mem_rdata_i, in, MEM_DW, beat data.
- mem_rerror_i, in, 1, beat error.
- mem_rlast_i, in, 1, final beat.
- mem_rvalid_i, in, 1, beat valid.
- mem_rready_o, out, 1, beat ready.
REQ-006 Lookup write port:
- write_addr_o, out, COUNT_ALIGN, line index.
- write_set_o, out, SET_ALIGN, set.
- write_data_o, out, LINE_WIDTH, line data.
- write_tag_o, out, TAG_WIDTH, tag.
- write_error_o, out, 1, line error.
- write_valid_o, out, 1, write valid.
- write_ready_i, in, 1, write ready.
REQ-007 Completion port:
- out_id_o, out, ID_WIDTH, miss ID.
- out_data_o, out, LINE_WIDTH, line data.
- out_error_o, out, 1, line error.
- out_valid_o, out, 1, completion valid.
- out_ready_i, in, 1, completion ready.

Function
REQ-008 The FSM SHALL have the states IDLE, REQ, RECV, WRITE and RSP; exactly one state SHALL be active per cycle.
REQ-009 in_ready_o SHALL be 1 only in IDLE; an in handshake SHALL register addr, set and id, clear the line buffer, the error bit and the beat counter, and move to REQ.
REQ-010 In REQ, mem_valid_o SHALL be 1, with mem_addr_o equal to the registered address with bits [LINE_ALIGN-1:0] zeroed; mem_valid_o SHALL first assert the cycle after the in handshake.
REQ-011 mem_valid_o SHALL be held stable with a constant address until mem_ready_i; the handshake SHALL move REQ to RECV.
REQ-012 In RECV, mem_rready_o SHALL be 1; beat k SHALL be written to line bits [k*MEM_DW +: MEM_DW], where k is the beat counter starting at 0 and incrementing per beat handshake.
REQ-013 The error bit SHALL be the sticky OR of mem_rerror_i over all accepted beats.
REQ-014 RECV SHALL move to WRITE on the beat handshake where mem_rlast_i=1 or k=LINE_WIDTH/MEM_DW-1, whichever comes first.
REQ-015 If mem_rlast_i=1 arrives with k<LINE_WIDTH/MEM_DW-1, the error bit SHALL be set and the unfilled bits SHALL remain 0.
REQ-016 Beats presented outside RECV SHALL NOT be accepted.
REQ-017 In WRITE, write_valid_o SHALL be 1, with:
- write_addr_o = addr[LINE_ALIGN +: COUNT_ALIGN];
- write_tag_o = addr >> (LINE_ALIGN+COUNT_ALIGN), truncated to TAG_WIDTH;
- write_set_o = registered set;
- write_data_o = line buffer;
- write_error_o = error bit.
REQ-018 The write handshake SHALL move WRITE to RSP; all write_* outputs SHALL be stable while write_valid_o=1.
REQ-019 In RSP, out_valid_o SHALL be 1, with out_id_o, out_data_o and out_error_o driven from the registers; the out handshake SHALL return to IDLE.
REQ-020 No new miss SHALL be accepted in the cycle the out handshake completes (in_ready_o=0 in RSP).
REQ-021 Minimum latency SHALL be 1 beat-free cycle plus one cycle per beat, plus 1 cycle for WRITE and 1 cycle for RSP: 5 cycles from the in handshake to the out handshake for 2 beats with all readies high.

Reset
REQ-022 On rst_ni=0, the state SHALL go to IDLE, and every register (address, set, id, line buffer, error, beat counter) SHALL clear to 0, asynchronously.
REQ-023 During reset: in_ready_o=1 is permitted only after deassertion; all other outputs SHALL be 0.
REQ-024 A reset mid-refill SHALL abandon the transfer; no write or completion SHALL be issued for that miss.

Structure
REQ-025 snitch_icache_pkg SHALL hold the refill request struct (addr, set, id); the FSM state enum SHALL stay local to the module.
REQ-026 No sub-module is needed; the beat counter width SHALL be max(1, $clog2(LINE_WIDTH/MEM_DW)).

Verification
REQ-027 Nominal: addr=0x0000_1234_5670, set=1, id=3, beats 0xAAAA..., 0xBBBB..., rlast on beat 1 -> mem_addr_o=0x...5670, write_addr_o=0x67, data={BBBB,AAAA}, error=0, out_id_o=3, 5 cycles.
REQ-028 Error beat: mem_rerror_i=1 on beat 0 only -> write_error_o=1 and out_error_o=1; data still written.
REQ-029 Early last: rlast=1 on beat 0 -> WRITE after 1 beat; data upper 64 bits =0; error=1.
REQ-030 Backpressure: mem_ready_i low 3 cycles, write_ready_i low 2 cycles, out_ready_i low 4 cycles -> all outputs held stable, no duplicate writes, in_ready_o=0 throughout.
REQ-031 Reset in RECV after beat 0 -> outputs 0; after release, a new miss with id=5 completes with out_id_o=5 and no stale data.
